// File: rtl/sram_weight_reader_if.sv
// sram_weight_reader_if: SRAM read port plus the outgoing weight-word stream.
// The master modport is the reader, the slave modport is the SRAM/consumer side.
interface sram_weight_reader_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 100
);
  logic              sram_csb;
  logic              sram_wsb;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output sram_csb, sram_wsb, sram_raddr,
    input  sram_rdata,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  sram_csb, sram_wsb, sram_raddr,
    output sram_rdata,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/sram_weight_reader.sv
// sram_weight_reader: read-side master for the 20000x100b weight SRAM.
// Issues one read per cycle over base..base+cnt-1 while credit allows,
// buffers returned words in a small FIFO and streams them with a last flag.
// Optional macro RD_STALL_CNT_EN enables the output backpressure counter.
module sram_weight_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 100,
  parameter int MAX_ADDR   = 19999,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [ADDR_W-1:0]    word_cnt_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [15:0]          stall_cnt_o,
  sram_weight_reader_if.master rd_if
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] issue_left_q;
  logic [ADDR_W-1:0] deliver_left_q;
  logic              inflight_q;
  logic              err_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

  logic [ADDR_W:0]   range_end;
  logic              cnt_zero;
  logic              range_bad;
  logic              start_acc;
  logic              start_rej;
  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_valid;

  // Range check is done one bit wider so base+cnt wrapping past 2^ADDR_W is caught.
  assign cnt_zero  = (word_cnt_i == '0);
  assign range_end = {1'b0, base_addr_i} + {1'b0, word_cnt_i} - (ADDR_W+1)'(1);
  assign range_bad = (range_end > (ADDR_W+1)'(MAX_ADDR));
  assign start_acc = (state_q == IDLE) && start_i && (cnt_zero || !range_bad);
  assign start_rej = (state_q == IDLE) && start_i && !cnt_zero && range_bad;

  // A word in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign credit_ok  = ((CNT_W+1)'(fifo_cnt_q) + (CNT_W+1)'(inflight_q))
                      < (CNT_W+1)'(FIFO_DEPTH);
  assign fifo_valid = (fifo_cnt_q != '0);
  assign push       = inflight_q;
  assign pop        = fifo_valid && rd_if.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: DRAIN ends when the final word is taken by the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i && cnt_zero)        state_d = DONE;
        else if (start_i && !range_bad) state_d = FETCH;
      end
      FETCH: if (issue && issue_left_q == ADDR_W'(1)) state_d = DRAIN;
      DRAIN: if (pop && deliver_left_q == ADDR_W'(1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs, including the per-cycle read issue decision.
  always_comb begin
    issue  = 1'b0;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      FETCH: begin
        busy_o = 1'b1;
        issue  = (issue_left_q != '0) && credit_ok;
      end
      DRAIN:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // Address/count sequencing, in-flight flag and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      inflight_q     <= 1'b0;
      err_q          <= 1'b0;
      fifo_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      err_q      <= start_rej;
      inflight_q <= issue;
      if (start_acc) begin
        addr_q       <= base_addr_i;
        issue_left_q <= word_cnt_i;
      end else if (issue) begin
        addr_q       <= addr_q + ADDR_W'(1);
        issue_left_q <= issue_left_q - ADDR_W'(1);
      end
      if (start_acc)  deliver_left_q <= word_cnt_i;
      else if (pop)   deliver_left_q <= deliver_left_q - ADDR_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Capture SRAM read data one cycle after the issue.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= rd_if.sram_rdata;
  end

  assign err_o            = err_q;
  assign rd_if.sram_csb   = !issue;
  assign rd_if.sram_wsb   = 1'b1;
  assign rd_if.sram_raddr = addr_q;
  assign rd_if.out_valid  = fifo_valid;
  assign rd_if.out_data   = fifo_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign rd_if.out_last   = fifo_valid && (deliver_left_q == ADDR_W'(1));

`ifdef RD_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of backpressured cycles, cleared on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (start_acc)
      stall_q <= '0;
    else if (busy_o && fifo_valid && !rd_if.out_ready && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sram_weight_reader.sv
// tb_sram_weight_reader: randomized self-checking bench for sram_weight_reader.
// The SRAM is modelled as a registered-read memory whose contents are a hash
// of address and a per-run salt; expectations come from the word range itself.
module tb_sram_weight_reader;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [14:0] base_addr_i;
  logic [14:0] word_cnt_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] stall_cnt_o;

  sram_weight_reader_if #(.ADDR_W(15), .DATA_W(100)) ifc ();

  sram_weight_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .word_cnt_i  (word_cnt_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .stall_cnt_o (stall_cnt_o),
    .rd_if       (ifc)
  );

  int          nCompared;
  int          nMismatched;
  int unsigned salt;
  int          lastMaxOcc;

  int          issAddr[$];
  int          issCyc[$];
  logic [99:0] accData[$];
  bit          accLast[$];
  int          accCyc[$];

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Content of SRAM word addr for the current run.
  function automatic logic [99:0] wordOf(input int unsigned addr);
    logic [31:0] h;
    h = (addr * 32'h9E3779B1) ^ salt;
    return {salt, h, ~h, addr[3:0]};
  endfunction

  // Registered-read SRAM: data for the address issued this cycle appears next cycle.
  initial ifc.sram_rdata = '0;
  always @(posedge clk) begin
    if (ifc.sram_csb === 1'b0) ifc.sram_rdata <= wordOf(32'(ifc.sram_raddr));
  end

  // Hard stop in case the flow itself stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string name, input logic [127:0] observed,
                             input logic [127:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, observed, expected);
    end
  endtask

  // All outputs at their reset values.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "/busy"},  128'(busy_o),          128'(0));
    checkOutput({tag, "/done"},  128'(done_o),          128'(0));
    checkOutput({tag, "/err"},   128'(err_o),           128'(0));
    checkOutput({tag, "/stall"}, 128'(stall_cnt_o),     128'(0));
    checkOutput({tag, "/csb"},   128'(ifc.sram_csb),    128'(1));
    checkOutput({tag, "/wsb"},   128'(ifc.sram_wsb),    128'(1));
    checkOutput({tag, "/raddr"}, 128'(ifc.sram_raddr),  128'(0));
    checkOutput({tag, "/valid"}, 128'(ifc.out_valid),   128'(0));
    checkOutput({tag, "/last"},  128'(ifc.out_last),    128'(0));
    checkOutput({tag, "/data"},  128'(ifc.out_data),    128'(0));
  endtask

  // Consumer readiness: 0 = always ready, 1 = low for cycles 0-7, 2 = random.
  function automatic bit readyFor(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc >= 8);
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Run one request and check it against the expected word range.
  task automatic applyStimulus(input string tag, input int base, input int cnt,
                               input int mode, input int restartCycle,
                               input int abortAfter, input bit expectErr);
    int   doneSeen, doneCyc, errSeen, errCyc, busySeen, busyLate, validSeen;
    int   maxOcc, holdBad, wsbBad, stallMeas, budget, occ, nCmp;
    bit   busyFirst, prevHeld, rdy;
    logic [99:0] prevData;
    int   expStall;

    issAddr.delete(); issCyc.delete();
    accData.delete(); accLast.delete(); accCyc.delete();
    salt = $urandom();
    doneSeen = 0; doneCyc = -1; errSeen = 0; errCyc = -1; busySeen = 0;
    busyLate = 0; validSeen = 0; maxOcc = 0; holdBad = 0; wsbBad = 0;
    stallMeas = 0; busyFirst = 0; prevHeld = 0; prevData = '0;
    budget = 60 + 12 * cnt;

    @(negedge clk);
    start_i       = 1'b1;
    base_addr_i   = 15'(base);
    word_cnt_i    = 15'(cnt);
    ifc.out_ready = readyFor(mode, 0);

    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start_i = (cyc == restartCycle);
      if (cyc == restartCycle) begin
        base_addr_i = 15'((base + 300) % 19000);
        word_cnt_i  = 15'(2);
      end
      rdy = readyFor(mode, cyc);
      ifc.out_ready = rdy;
      #1;
      if (ifc.sram_csb === 1'b0) begin
        issAddr.push_back(int'(ifc.sram_raddr));
        issCyc.push_back(cyc);
      end
      if (ifc.sram_wsb !== 1'b1) wsbBad++;
      occ = issAddr.size() - accData.size();
      if (occ > maxOcc) maxOcc = occ;
      if (prevHeld && (ifc.out_valid !== 1'b1 || ifc.out_data !== prevData)) holdBad++;
      if (ifc.out_valid && !rdy && busy_o) stallMeas++;
      if (ifc.out_valid) validSeen++;
      if (err_o) begin errSeen++; errCyc = cyc; end
      if (done_o) begin doneSeen++; doneCyc = cyc; end
      if (busy_o) begin
        busySeen++;
        if (cyc == 1) busyFirst = 1'b1;
        if (doneCyc >= 0) busyLate++;
      end
      if (ifc.out_valid && rdy) begin
        accData.push_back(ifc.out_data);
        accLast.push_back(ifc.out_last);
        accCyc.push_back(cyc);
      end
      prevHeld = ifc.out_valid && !rdy;
      prevData = ifc.out_data;

      if (abortAfter >= 0 && accData.size() == abortAfter) begin
        #2 rst_n = 1'b0;
        #1 checkResetOutputs({tag, "/abort"});
        repeat (2) @(negedge clk);
        checkResetOutputs({tag, "/held"});
        rst_n = 1'b1;
        return;
      end
      if (expectErr && cyc >= 6) break;
      if (doneCyc >= 0 && cyc >= doneCyc + 2) break;
    end
    lastMaxOcc = maxOcc;

    if (expectErr) begin
      checkOutput({tag, "/errPulses"}, 128'(errSeen),        128'(1));
      checkOutput({tag, "/errCycle"},  128'(errCyc),         128'(1));
      checkOutput({tag, "/issues"},    128'(issAddr.size()), 128'(0));
      checkOutput({tag, "/busy"},      128'(busySeen),       128'(0));
      checkOutput({tag, "/done"},      128'(doneSeen),       128'(0));
      return;
    end

    checkOutput({tag, "/donePulses"},  128'(doneSeen),        128'(1));
    checkOutput({tag, "/errPulses"},   128'(errSeen),         128'(0));
    checkOutput({tag, "/issueCount"},  128'(issAddr.size()),  128'(cnt));
    checkOutput({tag, "/acceptCount"}, 128'(accData.size()),  128'(cnt));
    checkOutput({tag, "/busyAfter"},   128'(busyLate),        128'(0));
    checkOutput({tag, "/overCredit"},  128'(maxOcc > 4),      128'(0));
    checkOutput({tag, "/holdStable"},  128'(holdBad),         128'(0));
    checkOutput({tag, "/wsb"},         128'(wsbBad),          128'(0));

    nCmp = (issAddr.size() < cnt) ? issAddr.size() : cnt;
    for (int i = 0; i < nCmp; i++)
      checkOutput({tag, "/addr"}, 128'(issAddr[i]), 128'(base + i));
    nCmp = (accData.size() < cnt) ? accData.size() : cnt;
    for (int i = 0; i < nCmp; i++) begin
      checkOutput({tag, "/data"}, 128'(accData[i]), 128'(wordOf(32'(base + i))));
      checkOutput({tag, "/last"}, 128'(accLast[i]), 128'(i == cnt - 1));
    end

    if (cnt == 0) begin
      checkOutput({tag, "/doneCycle"}, 128'(doneCyc),   128'(1));
      checkOutput({tag, "/valid"},     128'(validSeen), 128'(0));
      checkOutput({tag, "/busy"},      128'(busySeen),  128'(0));
    end else begin
      checkOutput({tag, "/busyFirst"}, 128'(busyFirst), 128'(1));
      if (accCyc.size() == cnt)
        checkOutput({tag, "/doneCycle"}, 128'(doneCyc), 128'(accCyc[cnt-1] + 1));
      if (mode == 0) begin
        for (int i = 0; i < issCyc.size() && i < cnt; i++)
          checkOutput({tag, "/issueCycle"}, 128'(issCyc[i]), 128'(i + 1));
        for (int i = 0; i < accCyc.size() && i < cnt; i++)
          checkOutput({tag, "/acceptCycle"}, 128'(accCyc[i]), 128'(i + 3));
      end
    end

`ifdef RD_STALL_CNT_EN
    expStall = stallMeas;
`else
    expStall = 0;
`endif
    checkOutput({tag, "/stallCnt"}, 128'(stall_cnt_o), 128'(expStall));
  endtask

  // Directed scenarios followed by randomized ranges under random backpressure.
  initial begin
    int cnt, base;
    nCompared     = 0;
    nMismatched   = 0;
    salt          = 0;
    lastMaxOcc    = 0;
    start_i       = 1'b0;
    base_addr_i   = '0;
    word_cnt_i    = '0;
    ifc.out_ready = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #2 checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("basic21",     21,    3,     0, -1, -1, 1'b0);
    applyStimulus("stall1100",   1100,  10,    1, -1, -1, 1'b0);
    checkOutput("stall1100/fullCredit", 128'(lastMaxOcc), 128'(4));
    applyStimulus("zeroCnt",     int'($urandom_range(0, 19999)), 0, 0, -1, -1, 1'b0);
    applyStimulus("rangeErr",    19998, 3,     0, -1, -1, 1'b1);
    applyStimulus("wrapErr",     32767, 32767, 0, -1, -1, 1'b1);
    applyStimulus("topEdge",     19997, 3,     0, -1, -1, 1'b0);
    applyStimulus("restart",     500,   5,     0,  2, -1, 1'b0);
    applyStimulus("abort",       4000,  6,     0, -1,  2, 1'b0);
    applyStimulus("afterAbort",  7000,  6,     2, -1, -1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      cnt  = int'($urandom_range(1, 24));
      base = int'($urandom_range(0, 20000 - cnt));
      applyStimulus("random", base, cnt, 2, -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/sram_weight_reader.md
Name: sram_weight_reader

Overview:
- Read-side master for the 20000x100b weight SRAM. Sequences read requests over a contiguous word range: `base_addr` .. `base_addr+word_cnt-1`.
- Absorbs the SRAM's 1-cycle registered read latency and buffers returned 100-bit words (25 x 4-bit weights) in a small FIFO.
- Streams the words to the systolic-array weight loader over a valid/ready interface with a last-word flag.

Parameters:
- ADDR_W, 15, SRAM address width.
- DATA_W, 100, SRAM word width.
- MAX_ADDR, 19999, highest legal SRAM word index.
- FIFO_DEPTH, 4, return-buffer depth in words (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word index.
- word_cnt  in  ADDR_W  number of words to read; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word has been handed off (or immediately for word_cnt=0).
- err  out  1  one-cycle pulse on a range-rejected start.
- sram_csb  out  1  SRAM chip enable, active low.
- sram_wsb  out  1  SRAM write enable, active low; constant 1.
- sram_raddr  out  ADDR_W  SRAM read address.
- sram_rdata  in  DATA_W  SRAM read data.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  DATA_W  weight word, FIFO head.
- out_last  out  1  qualifies out_data as the final word of the range.
- stall_cnt  out  16  backpressure counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except sram_csb=1 and sram_wsb=1. FIFO emptied, in-flight tracking cleared.
- SRAM timing:
  - A read is issued in cycle t by driving sram_csb=0 and sram_raddr=A.
  - sram_rdata for A is captured into the FIFO at the rising edge ending cycle t+1.
  - sram_csb=1 on all cycles with no issue.
- FSM states:
  - IDLE: on start:
    - word_cnt=0 -> DONE, no SRAM access.
    - base_addr+word_cnt-1 > MAX_ADDR (computed at ADDR_W+1 bits, so overflow is caught) -> err pulse next cycle, stay IDLE, no access.
    - otherwise latch base/count -> FETCH.
  - FETCH:
    - Issue one read per cycle while issued < word_cnt and (fifo_count + inflight) < FIFO_DEPTH.
    - Address increments by 1 per issue.
    - Once all words are issued -> DRAIN.
  - DRAIN: wait until the last word has been accepted at the output -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Credit rule: the FIFO never overflows, including with out_ready held low indefinitely. Issue stalls exactly when fifo_count + inflight = FIFO_DEPTH.
- FIFO read and write in the same cycle leave the count unchanged.
- Throughput: with out_ready held 1, one word per cycle after a 2-cycle initial latency (start edge -> first issue cycle -> out_valid).
- out_last=1 only while the head word is word index word_cnt-1. Cleared once that word is accepted.
- out_data/out_valid are stable while out_valid && !out_ready.
- start while busy: ignored; no effect on the current operation.
- rst_n asserted mid-operation: abort immediately, FIFO discarded, no done pulse; returned read data is dropped.

Optional Feature:
- Macro: RD_STALL_CNT_EN.
- Defined: stall_cnt counts cycles with out_valid && !out_ready while busy. It saturates at 16'hFFFF, clears to 0 on an accepted start, and holds its value in IDLE.
- Undefined: stall_cnt tied to 0 and no counter logic exists.

Test Plan:
- base_addr=21, word_cnt=3, out_ready=1, SRAM preloaded with mem[21..23]=A,B,C:
  - reads issued in 3 consecutive cycles at 21,22,23;
  - out_data A,B,C on consecutive cycles with out_last on C;
  - done pulse 1 cycle after C is accepted; busy low after.
- base_addr=1100, word_cnt=10, out_ready low for cycles 0-7 then high:
  - no more than 4 reads in flight or buffered;
  - sram_csb=1 during the stall;
  - all 10 words delivered in order with no loss or duplication;
  - stall_cnt equals the measured stall cycles when RD_STALL_CNT_EN is defined, otherwise 0.
- word_cnt=0 -> done pulse, sram_csb stays 1, out_valid never asserts.
- base_addr=19998, word_cnt=3 -> err pulse, no SRAM access, busy stays 0. base_addr=19997, word_cnt=3 -> succeeds with last address 19999.
- Second start pulsed mid-FETCH with different base_addr -> ignored; the original 5-word range completes unchanged.
- rst_n dropped after 2 of 6 words delivered -> outputs return to reset values asynchronously. A new start after release reads the full new range correctly with no stale data.
